// File: rtl/snooper_pkg.sv
// Shared types and width helpers for the AXI-Stream keep snooper.
package snooper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DROP
  } state_e;

  // Committed length can reach 2^addr_width full beats, hence the extra bit.
  function automatic int byte_len_width(input int data_width, input int addr_width);
    return addr_width + $clog2(data_width / 8) + 1;
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational count of asserted TKEEP byte qualifiers.
module keep_popcount #(
  parameter  int KEEP_WIDTH = 16,
  localparam int CNT_W      = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [CNT_W-1:0]      count_o
);

  // NOTE: the output gets a default before the loop so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count_o = count_o + CNT_W'(keep_i[i]);
    end
  end

endmodule

// File: rtl/axistream_keep_snooper.sv
// Passive AXI-Stream tap that copies whole packets into a word memory,
// reports their byte length, and counts packets it had to drop.
module axistream_keep_snooper
  import snooper_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DATA_WIDTH-1:0]                             TDATA,
  input  logic [DATA_WIDTH/8-1:0]                           TKEEP,
  input  logic                                              TVALID,
  input  logic                                              TREADY,
  input  logic                                              TLAST,
  input  logic                                              mem_ready,
  output logic [ADDR_WIDTH-1:0]                             wr_addr,
  output logic [DATA_WIDTH-1:0]                             wr_data,
  output logic                                              wr_en,
  output logic                                              done,
  output logic [byte_len_width(DATA_WIDTH, ADDR_WIDTH)-1:0] byte_len,
  output logic [CNT_WIDTH-1:0]                              drop_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int LEN_W  = byte_len_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int POP_W  = $clog2(KEEP_W + 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    full_q;
  logic                    commit_q;
  logic [LEN_W-1:0]        len_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    wr_en_q;
  logic                    done_q;
  logic [LEN_W-1:0]        byte_len_q;
  logic [CNT_WIDTH-1:0]    drop_cnt_q;

  logic                    beat;
  logic                    drop_event;
  logic [POP_W-1:0]        keep_cnt;
  logic [ADDR_WIDTH-1:0]   beat_idx;
  logic [LEN_W-1:0]        last_len;

  keep_popcount #(
    .KEEP_WIDTH (KEEP_W)
  ) u_keep_popcount (
    .keep_i  (TKEEP),
    .count_o (keep_cnt)
  );

  assign beat = TVALID && TREADY;

  // Only the last beat's TKEEP matters; earlier beats count as full words.
  always_comb begin
    beat_idx   = (state_q == CAPTURE) ? addr_q : '0;
    last_len   = LEN_W'(beat_idx) * LEN_W'(KEEP_W) + LEN_W'(keep_cnt);
    drop_event = beat && TLAST &&
                 ((state_q == DROP) ||
                  (state_q == IDLE && !mem_ready) ||
                  (state_q == CAPTURE && full_q));
  end

  // NOTE: all state and outputs are flops updated with non-blocking assignments, so every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      full_q     <= 1'b0;
      commit_q   <= 1'b0;
      len_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      byte_len_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_en_q  <= 1'b0;
      done_q   <= commit_q;
      commit_q <= 1'b0;
      if (commit_q) begin
        byte_len_q <= len_q;
      end
      if (drop_event && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end

      if (beat) begin
        unique case (state_q)
          IDLE: begin
            if (mem_ready) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= TDATA;
              addr_q    <= ADDR_WIDTH'(1);
              full_q    <= 1'b0;
              if (TLAST) begin
                commit_q <= 1'b1;
                len_q    <= last_len;
              end else begin
                state_q <= CAPTURE;
              end
            end else if (!TLAST) begin
              state_q <= DROP;
            end
          end
          CAPTURE: begin
            // A full memory turns the rest of the packet into a drop.
            if (full_q) begin
              state_q <= TLAST ? IDLE : DROP;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= TDATA;
              addr_q    <= addr_q + ADDR_WIDTH'(1);
              full_q    <= &addr_q;
              if (TLAST) begin
                commit_q <= 1'b1;
                len_q    <= last_len;
                state_q  <= IDLE;
              end
            end
          end
          DROP: begin
            if (TLAST) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign done     = done_q;
  assign byte_len = byte_len_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_axistream_keep_snooper.sv
// Directed bench for axistream_keep_snooper: default instance plus a 2-bit drop counter instance.
module tb_axistream_keep_snooper;

  localparam int DW = 128;
  localparam int AW = 8;
  localparam int KW = 16;
  localparam int LW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] TDATA;
  logic [KW-1:0] TKEEP;
  logic          TVALID, TREADY, TLAST, mem_ready;

  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, done;
  logic [LW-1:0] byte_len;
  logic [15:0]   drop_cnt;

  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_wr_data;
  logic          s_wr_en, s_done;
  logic [LW-1:0] s_byte_len;
  logic [1:0]    s_drop_cnt;

  axistream_keep_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID),
    .TREADY(TREADY), .TLAST(TLAST), .mem_ready(mem_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
    .byte_len(byte_len), .drop_cnt(drop_cnt)
  );

  axistream_keep_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID),
    .TREADY(TREADY), .TLAST(TLAST), .mem_ready(mem_ready),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_en(s_wr_en), .done(s_done),
    .byte_len(s_byte_len), .drop_cnt(s_drop_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_cyc[$];
  logic [LW-1:0] dq_len[$];
  int            dq_cyc[$];

  // Log every write and done pulse with the cycle of the edge that produced it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      dq_len.push_back(byte_len);
      dq_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    dq_len.delete();  dq_cyc.delete();
  endtask

  task automatic step(input logic v, input logic r, input logic l, input logic [KW-1:0] k,
                      input logic [DW-1:0] d, input logic mr, output int c);
    @(negedge clk);
    TVALID = v; TREADY = r; TLAST = l; TKEEP = k; TDATA = d; mem_ready = mr;
    @(posedge clk);
    #2;
    c = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, c);
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i == 2, 16'hFFFF, 128'hDEAD, 1'b1, c);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    total++; if (byte_len !== '0) begin bad++; $display("FAIL reset_byte_len: got %0d want 0", byte_len); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    total++; if (s_drop_cnt !== '0) begin bad++; $display("FAIL reset_sat_drop_cnt: got %0d want 0", s_drop_cnt); end
    rst = 1'b0;
    idle(1);
  endtask

  // mem_ready drops after the first beat and non-last TKEEP is partial; both must be ignored.
  task automatic test_four_beat();
    int bc[4];
    clear_logs();
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, i == 3, (i == 3) ? 16'h00FF : 16'h000F, 128'(32'hA0 + i), i == 0, bc[i]);
    idle(3);
    total++; if (wq_addr.size() !== 4) begin bad++; $display("FAIL four_write_count: got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      total++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== 128'(32'hA0 + i) || wq_cyc[i] !== bc[i]) begin
        bad++;
        $display("FAIL four_write%0d: got addr=%0d data=%0h cyc=%0d want addr=%0d data=%0h cyc=%0d",
                 i, wq_addr[i], wq_data[i], wq_cyc[i], i, 32'hA0 + i, bc[i]);
      end
    end
    total++; if (dq_len.size() !== 1) begin bad++; $display("FAIL four_done_count: got %0d want 1", dq_len.size()); end
    if (dq_len.size() > 0) begin
      total++; if (dq_len[0] !== 13'd56) begin bad++; $display("FAIL four_byte_len: got %0d want 56", dq_len[0]); end
      total++; if (dq_cyc[0] !== bc[3] + 1) begin bad++; $display("FAIL four_done_cyc: got %0d want %0d", dq_cyc[0], bc[3] + 1); end
    end
  endtask

  task automatic test_single_beat();
    int c;
    clear_logs();
    step(1'b1, 1'b1, 1'b1, 16'h0001, 128'h5151, 1'b1, c);
    idle(3);
    total++;
    if (wq_addr.size() !== 1) begin bad++; $display("FAIL single_write_count: got %0d want 1", wq_addr.size()); end
    else if (wq_addr[0] !== 8'd0 || wq_data[0] !== 128'h5151 || wq_cyc[0] !== c) begin
      bad++; $display("FAIL single_write: got addr=%0d data=%0h cyc=%0d want addr=0 data=5151 cyc=%0d",
                      wq_addr[0], wq_data[0], wq_cyc[0], c);
    end
    total++;
    if (dq_len.size() !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", dq_len.size()); end
    else if (dq_len[0] !== 13'd1 || dq_cyc[0] !== c + 1) begin
      bad++; $display("FAIL single_done: got len=%0d cyc=%0d want len=1 cyc=%0d", dq_len[0], dq_cyc[0], c + 1);
    end
  endtask

  task automatic test_zero_keep();
    int c;
    clear_logs();
    step(1'b1, 1'b1, 1'b0, 16'h0000, 128'h7, 1'b1, c);
    step(1'b1, 1'b1, 1'b1, 16'h0000, 128'h8, 1'b1, c);
    idle(3);
    total++;
    if (dq_len.size() !== 1) begin bad++; $display("FAIL zero_keep_done_count: got %0d want 1", dq_len.size()); end
    else if (dq_len[0] !== 13'd16) begin bad++; $display("FAIL zero_keep_len: got %0d want 16", dq_len[0]); end
    total++; if (wq_addr.size() !== 2) begin bad++; $display("FAIL zero_keep_writes: got %0d want 2", wq_addr.size()); end
  endtask

  task automatic test_drop_not_ready();
    int c;
    clear_logs();
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 128'h11, 1'b0, c);
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 128'h12, 1'b1, c);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, 128'h13, 1'b1, c);
    idle(3);
    total++; if (wq_addr.size() !== 0) begin bad++; $display("FAIL drop_writes: got %0d want 0", wq_addr.size()); end
    total++; if (dq_len.size() !== 0) begin bad++; $display("FAIL drop_dones: got %0d want 0", dq_len.size()); end
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL drop_cnt_first: got %0d want 1", drop_cnt); end
    total++; if (byte_len !== 13'd16) begin bad++; $display("FAIL drop_len_hold: got %0d want 16", byte_len); end
  endtask

  task automatic test_overflow();
    int c;
    int bc[2];
    clear_logs();
    for (int i = 0; i < 257; i++) step(1'b1, 1'b1, i == 256, 16'hFFFF, 128'(i), 1'b1, c);
    idle(3);
    total++; if (wq_addr.size() !== 256) begin bad++; $display("FAIL ovf_write_count: got %0d want 256", wq_addr.size()); end
    for (int i = 0; i < 256 && i < wq_addr.size(); i++) begin
      total++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== 128'(i)) begin
        bad++; $display("FAIL ovf_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq_addr[i], wq_data[i], i, i);
      end
    end
    total++; if (dq_len.size() !== 0) begin bad++; $display("FAIL ovf_dones: got %0d want 0", dq_len.size()); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
    clear_logs();
    step(1'b1, 1'b1, 1'b0, 16'h0000, 128'hF0, 1'b1, bc[0]);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, 128'hF1, 1'b1, bc[1]);
    idle(3);
    total++;
    if (wq_addr.size() !== 2) begin bad++; $display("FAIL ovf_next_writes: got %0d want 2", wq_addr.size()); end
    else if (wq_addr[0] !== 8'd0 || wq_addr[1] !== 8'd1 || wq_data[1] !== 128'hF1) begin
      bad++; $display("FAIL ovf_next_addr: got %0d,%0d data=%0h want 0,1 data=f1", wq_addr[0], wq_addr[1], wq_data[1]);
    end
    total++;
    if (dq_len.size() !== 1) begin bad++; $display("FAIL ovf_next_done: got %0d want 1", dq_len.size()); end
    else if (dq_len[0] !== 13'd32 || dq_cyc[0] !== bc[1] + 1) begin
      bad++; $display("FAIL ovf_next_len: got len=%0d cyc=%0d want len=32 cyc=%0d", dq_len[0], dq_cyc[0], bc[1] + 1);
    end
  endtask

  task automatic test_back_to_back();
    int bc[4];
    int c;
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    ea = '{8'd0, 8'd1, 8'd0, 8'd1};
    ed = '{128'hA0, 128'hA1, 128'hB0, 128'hB1};
    clear_logs();
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 128'hA0, 1'b1, bc[0]);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 128'hEE, 1'b0, c);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 128'hEF, 1'b0, c);
    step(1'b1, 1'b1, 1'b1, 16'h0007, 128'hA1, 1'b0, bc[1]);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 128'hB0, 1'b1, bc[2]);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 128'hEF, 1'b1, c);
    step(1'b1, 1'b1, 1'b1, 16'h8001, 128'hB1, 1'b0, bc[3]);
    idle(3);
    total++; if (wq_addr.size() !== 4) begin bad++; $display("FAIL b2b_write_count: got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      total++;
      if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i] || wq_cyc[i] !== bc[i]) begin
        bad++; $display("FAIL b2b_write%0d: got addr=%0d data=%0h cyc=%0d want addr=%0d data=%0h cyc=%0d",
                        i, wq_addr[i], wq_data[i], wq_cyc[i], ea[i], ed[i], bc[i]);
      end
    end
    total++; if (dq_len.size() !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", dq_len.size()); end
    if (dq_len.size() == 2) begin
      total++;
      if (dq_len[0] !== 13'd19 || dq_cyc[0] !== bc[1] + 1) begin
        bad++; $display("FAIL b2b_done_a: got len=%0d cyc=%0d want len=19 cyc=%0d", dq_len[0], dq_cyc[0], bc[1] + 1);
      end
      total++;
      if (dq_len[1] !== 13'd18 || dq_cyc[1] !== bc[3] + 1) begin
        bad++; $display("FAIL b2b_done_b: got len=%0d cyc=%0d want len=18 cyc=%0d", dq_len[1], dq_cyc[1], bc[3] + 1);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int c;
    int bc;
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    ea = '{8'd0, 8'd1, 8'd0, 8'd1};
    ed = '{128'hC0, 128'hC1, 128'hD0, 128'hD1};
    clear_logs();
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 128'hC0, 1'b1, c);
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 128'hC1, 1'b1, c);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 16'h0000, 128'h0, 1'b1, c);
    rst = 1'b0;
    total++; if (byte_len !== '0) begin bad++; $display("FAIL rstmid_byte_len: got %0d want 0", byte_len); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL rstmid_drop_cnt: got %0d want 0", drop_cnt); end
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 128'hD0, 1'b1, c);
    step(1'b1, 1'b1, 1'b1, 16'h0003, 128'hD1, 1'b1, bc);
    idle(3);
    total++; if (wq_addr.size() !== 4) begin bad++; $display("FAIL rstmid_write_count: got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      total++;
      if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
        bad++; $display("FAIL rstmid_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h",
                        i, wq_addr[i], wq_data[i], ea[i], ed[i]);
      end
    end
    total++;
    if (dq_len.size() !== 1) begin bad++; $display("FAIL rstmid_done_count: got %0d want 1", dq_len.size()); end
    else if (dq_len[0] !== 13'd18 || dq_cyc[0] !== bc + 1) begin
      bad++; $display("FAIL rstmid_done: got len=%0d cyc=%0d want len=18 cyc=%0d", dq_len[0], dq_cyc[0], bc + 1);
    end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL rstmid_no_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_saturate();
    int c;
    logic [15:0] em[4];
    logic [1:0]  es[4];
    em = '{16'd1, 16'd2, 16'd3, 16'd4};
    es = '{2'd1, 2'd2, 2'd3, 2'd3};
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 16'hFFFF, 128'(32'hE0 + i), 1'b0, c);
      total++;
      if (drop_cnt !== em[i] || s_drop_cnt !== es[i]) begin
        bad++; $display("FAIL sat_drop%0d: got main=%0d sat=%0d want main=%0d sat=%0d",
                        i, drop_cnt, s_drop_cnt, em[i], es[i]);
      end
    end
    idle(2);
    total++;
    if (wq_addr.size() !== 0 || dq_len.size() !== 0) begin
      bad++; $display("FAIL sat_no_traffic: got writes=%0d dones=%0d want 0 0", wq_addr.size(), dq_len.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    TVALID = 1'b0; TREADY = 1'b0; TLAST = 1'b0; TKEEP = '0; TDATA = '0; mem_ready = 1'b0;
    test_reset();
    test_four_beat();
    test_single_beat();
    test_zero_keep();
    test_drop_not_ready();
    test_overflow();
    test_back_to_back();
    test_reset_mid_packet();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
